// File: rtl/period_meter.sv
// Period / high-time meter for a slow asynchronous square wave.
// The input is brought into the clk domain with a two-flop synchronizer plus
// one extra flop, which gives a one-cycle rising-edge strobe. Between two
// strobes one counter runs every cycle and a second one runs only while the
// synced level is high. On each strobe both counts are published together
// with a single-cycle valid pulse. If no strobe arrives for TIMEOUT cycles,
// the meter raises timeout and re-arms. The next edge then only restarts
// counting and does not publish a result.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   ARMED   | waiting for a first edge; counters parked at 0, no results
//   MEASURE | counting since the last edge; next edge publishes a result
module period_meter #(
  parameter int unsigned     WIDTH   = 18,
  parameter logic [WIDTH-1:0] TIMEOUT = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sig_in,
  output logic [WIDTH-1:0] period,
  output logic [WIDTH-1:0] high_time,
  output logic             meas_valid,
  output logic             timeout
);

  typedef enum logic {
    ARMED   = 1'b0,
    MEASURE = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic s1_q, s2_q, s3_q;
  logic rise;

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_cnt_q, hi_cnt_d;
  logic [WIDTH-1:0] period_q, period_d;
  logic [WIDTH-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;

  // s1/s2 form the metastability filter; s3 is one cycle behind s2 so that
  // rise is a one-cycle strobe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q <= 1'b0;
      s2_q <= 1'b0;
      s3_q <= 1'b0;
    end else begin
      s1_q <= sig_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  assign rise = s2_q & ~s3_q;

  // State, counters and published results.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ARMED;
      cnt_q     <= '0;
      hi_cnt_q  <= '0;
      period_q  <= '0;
      high_q    <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_cnt_q  <= hi_cnt_d;
      period_q  <= period_d;
      high_q    <= high_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state and counter logic. An edge takes priority over the timeout
  // compare, so a period of exactly TIMEOUT cycles is still reported. The
  // counters saturate at TIMEOUT. The timeout compare normally leaves MEASURE
  // before saturation is reached, so saturation is only a guard against wrap.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_cnt_d  = hi_cnt_q;
    period_d  = period_q;
    high_d    = high_q;
    valid_d   = 1'b0;
    timeout_d = timeout_q;

    case (state_q)
      ARMED: begin
        cnt_d    = '0;
        hi_cnt_d = '0;
        if (rise) begin
          state_d   = MEASURE;
          cnt_d     = WIDTH'(1);
          hi_cnt_d  = WIDTH'(1);
          timeout_d = 1'b0;
        end
      end

      MEASURE: begin
        if (rise) begin
          period_d = cnt_q;
          high_d   = hi_cnt_q;
          valid_d  = 1'b1;
          cnt_d    = WIDTH'(1);
          hi_cnt_d = WIDTH'(1);
        end else if (cnt_q == TIMEOUT) begin
          state_d   = ARMED;
          timeout_d = 1'b1;
          cnt_d     = '0;
          hi_cnt_d  = '0;
        end else begin
          if (cnt_q != TIMEOUT) begin
            cnt_d = cnt_q + WIDTH'(1);
          end
          if (s2_q && (hi_cnt_q != TIMEOUT)) begin
            hi_cnt_d = hi_cnt_q + WIDTH'(1);
          end
        end
      end

      default: begin
        state_d  = ARMED;
        cnt_d    = '0;
        hi_cnt_d = '0;
      end
    endcase
  end

  assign period     = period_q;
  assign high_time  = high_q;
  assign meas_valid = valid_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_period_meter.sv
// Bench for period_meter. It uses two instances:
// - a short-timeout instance (TIMEOUT=63) for the directed sequences, and
// - a full-width default instance that measures a long period concurrently.
// The model works on edge timestamps:
// - period is the difference between rise cycles,
// - high time is a count of synced-high cycles.
`timescale 1ns/1ps
module tb_period_meter;

  localparam int W = 18;

  logic clk;
  logic rst_s, rst_b;
  logic sig_s, sig_b;
  logic [W-1:0] per_s, hi_s, per_b, hi_b;
  logic val_s, to_s, val_b, to_b;

  int n_checks = 0;
  int n_errors = 0;
  int nv_s = 0;
  int nv_b = 0;

  period_meter #(.WIDTH(W), .TIMEOUT(18'd63)) u_small (
    .clk(clk), .reset(rst_s), .sig_in(sig_s),
    .period(per_s), .high_time(hi_s), .meas_valid(val_s), .timeout(to_s)
  );

  period_meter #(.WIDTH(W)) u_big (
    .clk(clk), .reset(rst_b), .sig_in(sig_b),
    .period(per_b), .high_time(hi_b), .meas_valid(val_b), .timeout(to_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Timestamp model: one entry per instance (0 = small, 1 = big).
  int       lim[2] = '{63, 262143};
  bit       m_s1[2], m_s2[2], m_s3[2];
  bit       m_armed[2];
  int       m_t0[2], m_ones[2], cyc[2];
  longint   e_per[2], e_hi[2];
  bit       e_val[2], e_to[2];

  task automatic model_reset(input int i);
    m_s1[i] = 0; m_s2[i] = 0; m_s3[i] = 0;
    m_armed[i] = 1;
    m_t0[i] = 0; m_ones[i] = 0;
    e_per[i] = 0; e_hi[i] = 0; e_val[i] = 0; e_to[i] = 0;
  endtask

  task automatic model_step(input int i, input bit s);
    bit r;
    r = m_s2[i] & ~m_s3[i];
    e_val[i] = 0;
    if (m_armed[i]) begin
      if (r) begin
        m_armed[i] = 0; m_t0[i] = cyc[i]; m_ones[i] = 1; e_to[i] = 0;
      end
    end else if (r) begin
      e_per[i] = cyc[i] - m_t0[i];
      e_hi[i]  = m_ones[i];
      e_val[i] = 1;
      m_t0[i] = cyc[i]; m_ones[i] = 1;
    end else if (cyc[i] - m_t0[i] == lim[i]) begin
      e_to[i] = 1; m_armed[i] = 1;
    end else begin
      m_ones[i] += int'(m_s2[i]);
    end
    m_s3[i] = m_s2[i]; m_s2[i] = m_s1[i]; m_s1[i] = s;
    cyc[i]++;
  endtask

  always @(posedge clk or negedge rst_s)
    if (!rst_s) model_reset(0); else model_step(0, sig_s);

  always @(posedge clk or negedge rst_b)
    if (!rst_b) model_reset(1); else model_step(1, sig_b);

  // Per-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    chk("small period",     per_s, e_per[0]);
    chk("small high_time",  hi_s,  e_hi[0]);
    chk("small meas_valid", val_s, e_val[0]);
    chk("small timeout",    to_s,  e_to[0]);
    chk("big period",       per_b, e_per[1]);
    chk("big high_time",    hi_b,  e_hi[1]);
    chk("big meas_valid",   val_b, e_val[1]);
    chk("big timeout",      to_b,  e_to[1]);
    if (val_s) nv_s++;
    if (val_b) nv_b++;
  end

  task automatic wave_s(input int h, input int l, input int n);
    for (int k = 0; k < n; k++) begin
      sig_s = 1'b1; repeat (h) @(negedge clk);
      sig_s = 1'b0; repeat (l) @(negedge clk);
    end
  endtask

  int base;

  initial begin
    cyc[0] = 0; cyc[1] = 0;
    rst_s = 1'b0; rst_b = 1'b0;
    sig_s = 1'b0; sig_b = 1'b0;
    fork
      begin : small_seq
        // Held in reset while the input toggles.
        @(negedge clk);
        wave_s(5, 5, 3);
        chk("reset period", per_s, 0);
        chk("reset valid count", nv_s, 0);
        rst_s = 1'b1;
        repeat (5) @(negedge clk);

        // 5 high / 5 low.
        base = nv_s;
        wave_s(5, 5, 6);
        chk("5/5 pulses", nv_s - base, 5);
        chk("5/5 period", per_s, 10);
        chk("5/5 high", hi_s, 5);

        // 3/7 then 8/8.
        wave_s(3, 7, 3);
        chk("3/7 period", per_s, 10);
        chk("3/7 high", hi_s, 3);
        wave_s(8, 8, 3);
        chk("8/8 period", per_s, 16);
        chk("8/8 high", hi_s, 8);

        // Timeout after a 10-cycle measurement, then recovery.
        wave_s(5, 5, 3);
        repeat (80) @(negedge clk);
        chk("timeout raised", to_s, 1);
        chk("timeout period hold", per_s, 10);
        chk("timeout high hold", hi_s, 5);
        base = nv_s;
        wave_s(5, 5, 3);
        chk("recovery pulses", nv_s - base, 2);
        chk("recovery timeout", to_s, 0);

        // Asynchronous reset mid-period, released with the input high.
        wave_s(5, 5, 1);
        sig_s = 1'b1;
        repeat (2) @(negedge clk);
        #3 rst_s = 1'b0;
        #1;
        chk("async period", per_s, 0);
        chk("async high", hi_s, 0);
        chk("async valid", val_s, 0);
        chk("async timeout", to_s, 0);
        @(negedge clk);
        repeat (3) @(negedge clk);
        base = nv_s;
        rst_s = 1'b1;
        repeat (4) @(negedge clk);
        sig_s = 1'b0;
        repeat (5) @(negedge clk);
        wave_s(5, 5, 2);
        chk("post-reset pulses", nv_s - base, 2);
      end
      begin : big_seq
        repeat (3) @(negedge clk);
        rst_b = 1'b1;
        repeat (5) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
          sig_b = 1'b1; repeat (6001) @(negedge clk);
          sig_b = 1'b0; repeat (6001) @(negedge clk);
        end
        chk("long period", per_b, 12002);
        chk("long high", hi_b, 6001);
        chk("long timeout", to_b, 0);
        chk("long pulses", nv_b, 2);
      end
    join
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
